// File: rtl/divsqrt_result_queue.sv
// In-order result queue behind divSqrtFN: a slot is reserved at issue, filled on the outValid strobe, drained on a valid/ready port.
// Optional define DIVSQRT_RESULT_QUEUE_BYPASS_EN lets a completion landing on an empty head appear on the dequeue port in the same cycle.
module divsqrt_result_queue #(
   parameter int expWidth = 11,
   parameter int sigWidth = 53,
   parameter int depth    = 4,
   parameter int tagWidth = 4
) (
   input  logic                         nReset,
   input  logic                         clock,
   output logic                         issueAllow,
   input  logic                         issueFire,
   input  logic [tagWidth-1:0]          issueTag,
   input  logic                         outValid,
   input  logic                         sqrtOpOut,
   input  logic [expWidth+sigWidth-1:0] out,
   input  logic [4:0]                   exceptionFlags,
   output logic                         deqValid,
   input  logic                         deqReady,
   output logic [tagWidth-1:0]          deqTag,
   output logic                         deqSqrtOp,
   output logic [expWidth+sigWidth-1:0] deqOut,
   output logic [4:0]                   deqFlags,
   output logic [4:0]                   accruedFlags,
   input  logic                         clearFlags,
   output logic                         errOverflow,
   output logic                         errSpurious
);

   localparam int formatWidth = expWidth + sigWidth;
   localparam int idxW        = $clog2(depth);
   localparam int ptrW        = idxW + 1;
   localparam logic [ptrW-1:0] depthPtr = ptrW'(depth);
   localparam logic [ptrW-1:0] onePtr   = ptrW'(1);

   logic [ptrW-1:0]        r_allocPtr;
   logic [ptrW-1:0]        r_fillPtr;
   logic [ptrW-1:0]        r_readPtr;
   logic [tagWidth-1:0]    r_tag    [depth];
   logic                   r_sqrtOp [depth];
   logic [formatWidth-1:0] r_out    [depth];
   logic [4:0]             r_flags  [depth];
   logic [depth-1:0]       r_filled;

   logic [ptrW-1:0] w_reserved;
   logic [ptrW-1:0] w_pending;
   logic [idxW-1:0] w_allocIdx;
   logic [idxW-1:0] w_fillIdx;
   logic [idxW-1:0] w_readIdx;
   logic            w_issue;
   logic            w_complete;
   logic            w_headFilled;
   logic            w_bypass;
   logic            w_deq;
   logic            w_store;

   // Wrap bit in the MSB lets reserved reach exactly depth, which is how full is told apart from empty.
   assign w_reserved   = r_allocPtr - r_readPtr;
   assign w_pending    = r_allocPtr - r_fillPtr;
   assign w_allocIdx   = r_allocPtr[idxW-1:0];
   assign w_fillIdx    = r_fillPtr[idxW-1:0];
   assign w_readIdx    = r_readPtr[idxW-1:0];
   assign issueAllow   = (w_reserved != depthPtr);
   assign w_issue      = issueFire && issueAllow;
   assign w_complete   = outValid && (w_pending != '0);
   assign w_headFilled = (r_readPtr != r_fillPtr) && r_filled[w_readIdx];

`ifdef DIVSQRT_RESULT_QUEUE_BYPASS_EN
   assign w_bypass = !w_headFilled && w_complete;
`else
   assign w_bypass = 1'b0;
`endif

   // The tag always comes from the reserved slot; only the result fields take the live path when bypassing.
   always_comb begin
      deqValid  = w_headFilled;
      deqTag    = r_tag[w_readIdx];
      deqSqrtOp = r_sqrtOp[w_readIdx];
      deqOut    = r_out[w_readIdx];
      deqFlags  = r_flags[w_readIdx];
      if (w_bypass) begin
         deqValid  = 1'b1;
         deqSqrtOp = sqrtOpOut;
         deqOut    = out;
         deqFlags  = exceptionFlags;
      end
   end

   assign w_deq   = deqValid && deqReady;
   assign w_store = w_complete && !(w_bypass && deqReady);

   // Issue, completion and dequeue each own a pointer, so all three may fire in the same cycle.
   always_ff @(posedge clock) begin
      if (!nReset) begin
         r_allocPtr   <= '0;
         r_fillPtr    <= '0;
         r_readPtr    <= '0;
         r_filled     <= '0;
         accruedFlags <= '0;
         errOverflow  <= 1'b0;
         errSpurious  <= 1'b0;
         for (int i = 0; i < depth; i++) begin
            r_tag[i]    <= '0;
            r_sqrtOp[i] <= 1'b0;
            r_out[i]    <= '0;
            r_flags[i]  <= '0;
         end
      end else begin
         if (w_issue) begin
            r_tag[w_allocIdx]    <= issueTag;
            r_filled[w_allocIdx] <= 1'b0;
            r_allocPtr           <= r_allocPtr + onePtr;
         end
         if (w_store) begin
            r_sqrtOp[w_fillIdx] <= sqrtOpOut;
            r_out[w_fillIdx]    <= out;
            r_flags[w_fillIdx]  <= exceptionFlags;
            r_filled[w_fillIdx] <= 1'b1;
         end
         if (w_complete) begin
            r_fillPtr <= r_fillPtr + onePtr;
         end
         if (w_deq) begin
            r_readPtr <= r_readPtr + onePtr;
         end
         if (issueFire && !issueAllow) begin
            errOverflow <= 1'b1;
         end
         if (outValid && (w_pending == '0)) begin
            errSpurious <= 1'b1;
         end
         // A capture in the same cycle as a clear survives the clear.
         if (w_complete) begin
            accruedFlags <= (clearFlags ? 5'b00000 : accruedFlags) | exceptionFlags;
         end else if (clearFlags) begin
            accruedFlags <= 5'b00000;
         end
      end
   end

endmodule

// File: tb/tb_divsqrt_result_queue.sv
// Bench for divsqrt_result_queue: per-cycle vector table plus an in-order result scoreboard.
module tb_divsqrt_result_queue;

   localparam int DEPTH = 4;
`ifdef DIVSQRT_RESULT_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        nReset = 1'b0;
   logic        clock = 1'b0;
   logic        issueAllow;
   logic        issueFire = 1'b0;
   logic [3:0]  issueTag = '0;
   logic        outValid = 1'b0;
   logic        sqrtOpOut = 1'b0;
   logic [63:0] out = '0;
   logic [4:0]  exceptionFlags = '0;
   logic        deqValid;
   logic        deqReady = 1'b0;
   logic [3:0]  deqTag;
   logic        deqSqrtOp;
   logic [63:0] deqOut;
   logic [4:0]  deqFlags;
   logic [4:0]  accruedFlags;
   logic        clearFlags = 1'b0;
   logic        errOverflow;
   logic        errSpurious;

   divsqrt_result_queue #(.expWidth(11), .sigWidth(53), .depth(DEPTH), .tagWidth(4)) dut (
      .nReset(nReset), .clock(clock), .issueAllow(issueAllow), .issueFire(issueFire),
      .issueTag(issueTag), .outValid(outValid), .sqrtOpOut(sqrtOpOut), .out(out),
      .exceptionFlags(exceptionFlags), .deqValid(deqValid), .deqReady(deqReady),
      .deqTag(deqTag), .deqSqrtOp(deqSqrtOp), .deqOut(deqOut), .deqFlags(deqFlags),
      .accruedFlags(accruedFlags), .clearFlags(clearFlags), .errOverflow(errOverflow),
      .errSpurious(errSpurious)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        iss;
      logic [3:0]  itag;
      logic        ov;
      logic        sq;
      logic [63:0] o;
      logic [4:0]  fl;
      logic        rdy;
      logic        clr;
      logic        eAllow;
      logic        eDv;
      logic        eDvB;
      logic [3:0]  eTag;
      logic [3:0]  eTagB;
      logic [4:0]  eAcc;
      logic        eOvf;
      logic        eSpur;
   } vec_t;

   typedef struct packed {
      logic [3:0]  tag;
      logic        sq;
      logic [63:0] o;
      logic [4:0]  fl;
   } res_t;

   vec_t       vecs[$];
   logic [3:0] tagQ[$];
   res_t       resQ[$];
   int         nVec = 0;
   int         nMis = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      nVec++;
      if (act !== exp) begin
         nMis++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t stim(input logic iss, input logic [3:0] itag, input logic ov,
                                 input logic sq, input logic [63:0] o, input logic [4:0] fl,
                                 input logic rdy, input logic clr);
      vec_t v;
      v      = '0;
      v.iss  = iss;
      v.itag = itag;
      v.ov   = ov;
      v.sq   = sq;
      v.o    = o;
      v.fl   = fl;
      v.rdy  = rdy;
      v.clr  = clr;
      return v;
   endfunction

   task automatic addVec(input logic iss, input logic [3:0] itag, input logic ov, input logic sq,
                         input logic [63:0] o, input logic [4:0] fl, input logic rdy, input logic clr,
                         input logic eAllow, input logic eDv, input logic eDvB, input logic [3:0] eTag,
                         input logic [3:0] eTagB, input logic [4:0] eAcc, input logic eOvf,
                         input logic eSpur);
      vec_t v;
      v        = stim(iss, itag, ov, sq, o, fl, rdy, clr);
      v.eAllow = eAllow;
      v.eDv    = eDv;
      v.eDvB   = eDvB;
      v.eTag   = eTag;
      v.eTagB  = eTagB;
      v.eAcc   = eAcc;
      v.eOvf   = eOvf;
      v.eSpur  = eSpur;
      vecs.push_back(v);
   endtask

   // Inputs change on the falling edge; outputs are sampled 3 time units later, well before the rising edge.
   task automatic applyStimulus(input vec_t v);
      @(negedge clock);
      issueFire      = v.iss;
      issueTag       = v.itag;
      outValid       = v.ov;
      sqrtOpOut      = v.sq;
      out            = v.o;
      exceptionFlags = v.fl;
      deqReady       = v.rdy;
      clearFlags     = v.clr;
      #3;
   endtask

   task automatic checkOutput(input vec_t v, input int i);
      logic dvExp;
      dvExp = BYP ? v.eDvB : v.eDv;
      check($sformatf("v%0d issueAllow", i), 128'(issueAllow), 128'(v.eAllow));
      check($sformatf("v%0d deqValid", i), 128'(deqValid), 128'(dvExp));
      if (dvExp)
         check($sformatf("v%0d deqTag", i), 128'(deqTag), 128'(BYP ? v.eTagB : v.eTag));
      check($sformatf("v%0d accruedFlags", i), 128'(accruedFlags), 128'(v.eAcc));
      check($sformatf("v%0d errOverflow", i), 128'(errOverflow), 128'(v.eOvf));
      check($sformatf("v%0d errSpurious", i), 128'(errSpurious), 128'(v.eSpur));
   endtask

   // Model of the queue: issued tags wait in tagQ, completed results in resQ, dequeues pop in order.
   task automatic scoreboardStep();
      int   resv;
      bit   bypassed;
      res_t live;
      resv     = tagQ.size() + resQ.size();
      bypassed = 1'b0;
      if (deqValid && deqReady) begin
         if (resQ.size() > 0) begin
            check("deq record", 128'({deqTag, deqSqrtOp, deqOut, deqFlags}), 128'(resQ[0]));
            void'(resQ.pop_front());
         end else if (BYP && outValid && tagQ.size() > 0) begin
            live = {tagQ[0], sqrtOpOut, out, exceptionFlags};
            check("deq bypass record", 128'({deqTag, deqSqrtOp, deqOut, deqFlags}), 128'(live));
            bypassed = 1'b1;
         end else begin
            nVec++;
            nMis++;
            $display("[TB] FAIL deq empty: got deqValid=1, expected no result available");
         end
      end
      if (outValid && tagQ.size() > 0) begin
         live = {tagQ.pop_front(), sqrtOpOut, out, exceptionFlags};
         if (!bypassed) resQ.push_back(live);
      end
      if (issueFire && resv < DEPTH) tagQ.push_back(issueTag);
   endtask

   task automatic runCycle(input vec_t v);
      applyStimulus(v);
      scoreboardStep();
   endtask

   task automatic resetDut();
      @(negedge clock);
      nReset         = 1'b0;
      issueFire      = 1'b0;
      outValid       = 1'b0;
      deqReady       = 1'b0;
      clearFlags     = 1'b0;
      exceptionFlags = '0;
      repeat (2) @(posedge clock);
      #1;
      nReset = 1'b1;
      tagQ.delete();
      resQ.delete();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      //     iss tag ov sq out                    flags     rdy clr | allow dv dvB tag tagB acc      ovf spur
      addVec(0, 0,  0, 0, 64'h0,                 5'b00000, 0, 0,   1, 0, 0, 0, 0, 5'b00000, 0, 0);
      addVec(1, 1,  0, 0, 64'h0,                 5'b00000, 0, 0,   1, 0, 0, 0, 0, 5'b00000, 0, 0);
      addVec(1, 2,  0, 0, 64'h0,                 5'b00000, 0, 0,   1, 0, 0, 0, 0, 5'b00000, 0, 0);
      addVec(1, 3,  0, 0, 64'h0,                 5'b00000, 0, 0,   1, 0, 0, 0, 0, 5'b00000, 0, 0);
      addVec(1, 4,  0, 0, 64'h0,                 5'b00000, 0, 0,   1, 0, 0, 0, 0, 5'b00000, 0, 0);
      addVec(1, 9,  0, 0, 64'h0,                 5'b00000, 0, 0,   0, 0, 0, 0, 0, 5'b00000, 0, 0);
      addVec(0, 0,  0, 0, 64'h0,                 5'b00000, 0, 0,   0, 0, 0, 0, 0, 5'b00000, 1, 0);
      addVec(0, 0,  1, 0, 64'h3FF0000000000000,  5'b00001, 0, 0,   0, 0, 1, 1, 1, 5'b00000, 1, 0);
      addVec(0, 0,  0, 0, 64'h0,                 5'b00000, 0, 0,   0, 1, 1, 1, 1, 5'b00001, 1, 0);
      addVec(1, 5,  1, 1, 64'h4000000000000000,  5'b10000, 1, 0,   0, 1, 1, 1, 1, 5'b00001, 1, 0);
      addVec(0, 0,  0, 0, 64'h0,                 5'b00000, 0, 1,   1, 1, 1, 2, 2, 5'b10001, 1, 0);
      addVec(1, 5,  1, 0, 64'hC000000000000000,  5'b00100, 1, 0,   1, 1, 1, 2, 2, 5'b00000, 1, 0);
      addVec(0, 0,  0, 0, 64'h0,                 5'b00000, 0, 0,   1, 1, 1, 3, 3, 5'b00100, 1, 0);
      addVec(1, 6,  0, 0, 64'h0,                 5'b00000, 0, 0,   1, 1, 1, 3, 3, 5'b00100, 1, 0);
      addVec(0, 0,  0, 0, 64'h0,                 5'b00000, 0, 0,   0, 1, 1, 3, 3, 5'b00100, 1, 0);
      addVec(0, 0,  0, 0, 64'h0,                 5'b00000, 1, 0,   0, 1, 1, 3, 3, 5'b00100, 1, 0);
      addVec(0, 0,  0, 0, 64'h0,                 5'b00000, 0, 0,   1, 0, 0, 0, 0, 5'b00100, 1, 0);
      addVec(0, 0,  1, 0, 64'h0000000000000001,  5'b00010, 1, 0,   1, 0, 1, 4, 4, 5'b00100, 1, 0);
      addVec(0, 0,  0, 0, 64'h0,                 5'b00000, 1, 0,   1, 1, 0, 4, 4, 5'b00110, 1, 0);
      addVec(0, 0,  1, 0, 64'h0000000000000002,  5'b01000, 1, 0,   1, 0, 1, 5, 5, 5'b00110, 1, 0);
      addVec(0, 0,  1, 1, 64'h0000000000000003,  5'b00000, 1, 0,   1, 1, 1, 5, 6, 5'b01110, 1, 0);
      addVec(0, 0,  0, 0, 64'h0,                 5'b00000, 1, 0,   1, 1, 0, 6, 6, 5'b01110, 1, 0);
      addVec(0, 0,  0, 0, 64'h0,                 5'b00000, 0, 0,   1, 0, 0, 0, 0, 5'b01110, 1, 0);
      addVec(0, 0,  1, 0, 64'h0000000000000004,  5'b00001, 0, 0,   1, 0, 0, 0, 0, 5'b01110, 1, 0);
      addVec(0, 0,  0, 0, 64'h0,                 5'b00000, 0, 0,   1, 0, 0, 0, 0, 5'b01110, 1, 1);

      resetDut();
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i], i);
         scoreboardStep();
      end

      // Capture and clear together: the new flags survive.
      runCycle(stim(1, 8, 0, 0, 64'h0, 5'b00000, 0, 0));
      runCycle(stim(0, 0, 1, 1, 64'h0000000000000005, 5'b00001, 0, 1));
      check("clr+cap deqValid", 128'(deqValid), 128'(BYP));
      runCycle(stim(0, 0, 0, 0, 64'h0, 5'b00000, 0, 0));
      check("clr+cap accrued", 128'(accruedFlags), 128'(5'b00001));
      check("clr+cap deqValid next", 128'(deqValid), 128'(1'b1));
      check("clr+cap deqTag", 128'(deqTag), 128'(4'd8));
      runCycle(stim(0, 0, 0, 0, 64'h0, 5'b00000, 1, 0));

      // Completion onto an empty head with the consumer ready.
      runCycle(stim(1, 7, 0, 0, 64'h0, 5'b00000, 1, 0));
      runCycle(stim(0, 0, 0, 0, 64'h0, 5'b00000, 1, 0));
      check("byp idle deqValid", 128'(deqValid), 128'(1'b0));
      runCycle(stim(0, 0, 1, 0, 64'h0000000000000006, 5'b00000, 1, 0));
      check("byp same-cycle deqValid", 128'(deqValid), 128'(BYP));
      check("byp deqTag", 128'(deqTag), 128'(4'd7));
      runCycle(stim(0, 0, 0, 0, 64'h0, 5'b00000, 1, 0));
      check("byp next-cycle deqValid", 128'(deqValid), 128'(!BYP));

      // Fill after wrap-around, then reset mid-operation.
      for (int t = 10; t < 14; t++) begin
         runCycle(stim(1, 4'(t), 0, 0, 64'h0, 5'b00000, 0, 0));
         check($sformatf("wrap fill %0d issueAllow", t), 128'(issueAllow), 128'(1'b1));
      end
      runCycle(stim(0, 0, 0, 0, 64'h0, 5'b00000, 0, 0));
      check("wrap full issueAllow", 128'(issueAllow), 128'(1'b0));
      runCycle(stim(0, 0, 1, 0, 64'h0000000000000007, 5'b00010, 0, 0));
      resetDut();
      runCycle(stim(0, 0, 0, 0, 64'h0, 5'b00000, 0, 0));
      check("rst issueAllow", 128'(issueAllow), 128'(1'b1));
      check("rst deqValid", 128'(deqValid), 128'(1'b0));
      check("rst accruedFlags", 128'(accruedFlags), 128'(5'b00000));
      check("rst errOverflow", 128'(errOverflow), 128'(1'b0));
      check("rst errSpurious", 128'(errSpurious), 128'(1'b0));
      check("rst deqOut", 128'(deqOut), 128'(64'h0));
      check("rst deqTag", 128'(deqTag), 128'(4'd0));

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
